// File: rtl/i281_pkg.sv
// i281_pkg -- shared definitions for the i281 fetch/decode block.
//   * opcode constants for the two control-flow instructions
//   * branch condition codes (selected by the rx field of a BRANCH)
//   * fetch/decode state enumeration
//   * instruction field bit positions
//   * HALT_OFFSET: the jump offset that encodes "jump to self"
package i281_pkg;

    localparam logic [3:0] OP_JUMP   = 4'b1110;
    localparam logic [3:0] OP_BRANCH = 4'b1111;

    // Condition codes carried in rx of a BRANCH instruction
    localparam logic [1:0] COND_Z  = 2'b00;  // Z
    localparam logic [1:0] COND_NZ = 2'b01;  // !Z
    localparam logic [1:0] COND_GT = 2'b10;  // !Z & (N == V)
    localparam logic [1:0] COND_GE = 2'b11;  // N == V

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_EX,
        ST_HALT
    } state_t;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RX_MSB     = 11;
    localparam int RX_LSB     = 10;
    localparam int RY_MSB     = 9;
    localparam int RY_LSB     = 8;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    // pc + 1 + 4'hF == pc, so a JUMP with this offset never leaves its own address
    localparam logic [7:0] HALT_OFFSET = 8'hFF;

endpackage

// File: rtl/i281_branch_eval.sv
// i281_branch_eval -- combinational branch decision.
// Ports:
//   opcode  in  4  decoded opcode
//   rx      in  2  condition selector for BRANCH
//   flag_z, flag_n, flag_v  in  1  ALU flags
//   taken   out 1  1 when the pc must take the immediate offset
module i281_branch_eval
    import i281_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] rx,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_v,
    output logic       taken
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (rx)
            COND_Z:  cond = flag_z;
            COND_NZ: cond = ~flag_z;
            COND_GT: cond = ~flag_z & (flag_n == flag_v);
            COND_GE: cond = (flag_n == flag_v);
            default: cond = 1'b0;
        endcase
        taken = (opcode == OP_JUMP) | ((opcode == OP_BRANCH) & cond);
    end

endmodule

// File: rtl/i281_fetch_decode.sv
// i281_fetch_decode -- instruction fetch and decode with a ready/valid
// handshake toward the execute stage.
// Ports:
//   Clock, Reset        clock and asynchronous active-high reset
//   b0I..b15I   in 16   instruction ROM words (static)
//   run         in 1    fetch enable; low parks the block in IDLE
//   flag_z/n/v  in 1    ALU flags, sampled on the transfer edge
//   ex_ready    in 1    execute stage accepts the decoded instruction
//   pc          out 4   address of the instruction fetched or held
//   ir          out 16  latched instruction word
//   opcode, rx, ry, imm decoded fields of ir
//   ir_valid    out 1   decoded fields valid (WAIT_EX only)
//   halted      out 1   stopped on a jump-to-self
module i281_fetch_decode
    import i281_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] b0I,
    input  logic [15:0] b1I,
    input  logic [15:0] b2I,
    input  logic [15:0] b3I,
    input  logic [15:0] b4I,
    input  logic [15:0] b5I,
    input  logic [15:0] b6I,
    input  logic [15:0] b7I,
    input  logic [15:0] b8I,
    input  logic [15:0] b9I,
    input  logic [15:0] b10I,
    input  logic [15:0] b11I,
    input  logic [15:0] b12I,
    input  logic [15:0] b13I,
    input  logic [15:0] b14I,
    input  logic [15:0] b15I,
    input  logic        run,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_v,
    input  logic        ex_ready,
    output logic [3:0]  pc,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [1:0]  rx,
    output logic [1:0]  ry,
    output logic [7:0]  imm,
    output logic        ir_valid,
    output logic        halted
);

    state_t      state;
    logic [15:0] fetch_word;
    logic        taken;
    logic [3:0]  pc_seq;
    logic [3:0]  pc_taken;

    // 16:1 instruction selection by pc
    always_comb begin
        fetch_word = 16'h0000;
        case (pc)
            4'd0:    fetch_word = b0I;
            4'd1:    fetch_word = b1I;
            4'd2:    fetch_word = b2I;
            4'd3:    fetch_word = b3I;
            4'd4:    fetch_word = b4I;
            4'd5:    fetch_word = b5I;
            4'd6:    fetch_word = b6I;
            4'd7:    fetch_word = b7I;
            4'd8:    fetch_word = b8I;
            4'd9:    fetch_word = b9I;
            4'd10:   fetch_word = b10I;
            4'd11:   fetch_word = b11I;
            4'd12:   fetch_word = b12I;
            4'd13:   fetch_word = b13I;
            4'd14:   fetch_word = b14I;
            4'd15:   fetch_word = b15I;
            default: fetch_word = 16'h0000;
        endcase
    end

    i281_branch_eval u_branch_eval (
        .opcode (opcode),
        .rx     (rx),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_v (flag_v),
        .taken  (taken)
    );

    // 4-bit arithmetic gives the modulo-16 wrap; the 8-bit offset is
    // deliberately truncated to its low nibble.
    assign pc_seq   = pc + 4'd1;
    assign pc_taken = pc + 4'd1 + imm[3:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            pc       <= 4'd0;
            ir       <= 16'h0000;
            opcode   <= 4'd0;
            rx       <= 2'd0;
            ry       <= 2'd0;
            imm      <= 8'd0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    ir    <= fetch_word;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    opcode   <= ir[OPCODE_MSB:OPCODE_LSB];
                    rx       <= ir[RX_MSB:RX_LSB];
                    ry       <= ir[RY_MSB:RY_LSB];
                    imm      <= ir[IMM_MSB:IMM_LSB];
                    ir_valid <= 1'b1;
                    state    <= ST_WAIT_EX;
                end
                ST_WAIT_EX: begin
                    // Everything holds until the execute stage accepts.
                    if (ex_ready) begin
                        ir_valid <= 1'b0;
                        pc       <= taken ? pc_taken : pc_seq;
                        if (opcode == OP_JUMP && imm == HALT_OFFSET) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else if (run) begin
                            state <= ST_FETCH;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    // Only Reset leaves HALT.
                    state <= ST_HALT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i281_fetch_decode.sv
// tb_i281_fetch_decode -- self-checking bench for i281_fetch_decode.
// A small program-level model (ROM array + expected pc) predicts every
// fetched word, decoded field and next pc from the instruction-set rules.
module tb_i281_fetch_decode;

    logic        Clock;
    logic        Reset;
    logic        run;
    logic        flag_z, flag_n, flag_v;
    logic        ex_ready;
    logic [15:0] rom [16];
    logic [3:0]  pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [1:0]  rx, ry;
    logic [7:0]  imm;
    logic        ir_valid;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int mpc      = 0;   // model program counter

    i281_fetch_decode dut (
        .Clock(Clock), .Reset(Reset),
        .b0I(rom[0]),   .b1I(rom[1]),   .b2I(rom[2]),   .b3I(rom[3]),
        .b4I(rom[4]),   .b5I(rom[5]),   .b6I(rom[6]),   .b7I(rom[7]),
        .b8I(rom[8]),   .b9I(rom[9]),   .b10I(rom[10]), .b11I(rom[11]),
        .b12I(rom[12]), .b13I(rom[13]), .b14I(rom[14]), .b15I(rom[15]),
        .run(run), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .ex_ready(ex_ready),
        .pc(pc), .ir(ir), .opcode(opcode), .rx(rx), .ry(ry), .imm(imm),
        .ir_valid(ir_valid), .halted(halted)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next pc from the instruction-set rules, plain integer arithmetic.
    function automatic int model_next_pc(int p, logic [15:0] w, bit z, bit n, bit v);
        int op;
        int c;
        bit t;
        op = int'(w[15:12]);
        c  = int'(w[11:10]);
        if (op == 14) t = 1'b1;
        else if (op == 15) begin
            case (c)
                0:       t = z;
                1:       t = !z;
                2:       t = !z && (n == v);
                default: t = (n == v);
            endcase
        end else t = 1'b0;
        return t ? (p + 1 + int'(w[3:0])) % 16 : (p + 1) % 16;
    endfunction

    task automatic wait_valid();
        int n = 0;
        while (ir_valid !== 1'b1 && n < 12) begin
            @(negedge Clock);
            n++;
        end
        chk("valid_timeout", {31'd0, ir_valid}, 32'd1);
    endtask

    task automatic check_fields();
        logic [15:0] w;
        w = rom[mpc];
        chk("ir",     ir,     w);
        chk("opcode", opcode, w[15:12]);
        chk("rx",     rx,     w[11:10]);
        chk("ry",     ry,     w[9:8]);
        chk("imm",    imm,    w[7:0]);
        chk("pc",     pc,     mpc[3:0]);
    endtask

    // One full instruction: wait for valid, stall, hand over with flags.
    task automatic do_instr(int stall, bit z, bit n, bit v, bit run_after);
        logic [15:0] w;
        bit          exp_halt;
        int          prev;
        wait_valid();
        check_fields();
        ex_ready = 1'b0;
        run      = run_after;   // must not disturb the instruction in flight
        repeat (stall) begin
            @(negedge Clock);
            chk("stall_valid", {31'd0, ir_valid}, 32'd1);
            chk("stall_ir",    ir, rom[mpc]);
            chk("stall_pc",    pc, mpc[3:0]);
        end
        flag_z   = z;
        flag_n   = n;
        flag_v   = v;
        ex_ready = 1'b1;
        w        = rom[mpc];
        exp_halt = (w == 16'hE0FF);
        prev     = mpc;
        mpc      = model_next_pc(mpc, w, z, n, v);
        @(negedge Clock);
        ex_ready = 1'b0;
        chk("xfer_valid", {31'd0, ir_valid}, 32'd0);
        chk("xfer_pc",    pc, mpc[3:0]);
        chk("xfer_halt",  {31'd0, halted}, {31'd0, exp_halt});
        $display("instr pc=%0d word=%h zNV=%0d%0d%0d stall=%0d next_pc=%0d", prev, w, z, n, v, stall, mpc);
        if (!run_after && !exp_halt) begin
            repeat (3) @(negedge Clock);
            chk("idle_valid", {31'd0, ir_valid}, 32'd0);
            chk("idle_pc",    pc, mpc[3:0]);
            run = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
        rom[0]  = 16'h3004;
        rom[1]  = 16'hE00B;   // jump to 13
        rom[13] = 16'hF002;   // branch on Z, +2
        rom[14] = 16'hE000;   // jump +0 -> 15
        rom[15] = 16'h0000;
        Reset = 1'b1; run = 1'b0; ex_ready = 1'b0;
        flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0;

        // Reset state
        @(negedge Clock);
        chk("rst_pc", pc, 4'd0);
        chk("rst_ir", ir, 16'h0);
        chk("rst_fields", {opcode, rx, ry, imm}, 16'h0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // First fetch after reset: two cycles from FETCH entry to valid
        Reset = 1'b0; run = 1'b1; ex_ready = 1'b1;
        @(negedge Clock);   // entered FETCH
        chk("f0_valid", {31'd0, ir_valid}, 32'd0);
        @(negedge Clock);   // ir loaded
        chk("f1_ir", ir, 16'h3004);
        chk("f1_valid", {31'd0, ir_valid}, 32'd0);
        @(negedge Clock);   // decoded and valid
        chk("f2_valid", {31'd0, ir_valid}, 32'd1);
        chk("f2_ir", ir, 16'h3004);
        chk("f2_opcode", opcode, 4'd3);
        chk("f2_rxry", {rx, ry}, 4'd0);
        chk("f2_imm", imm, 8'h04);
        @(negedge Clock);   // accepted since ex_ready stayed high
        ex_ready = 1'b0;
        chk("f3_pc", pc, 4'd1);
        chk("f3_valid", {31'd0, ir_valid}, 32'd0);
        mpc = 1;

        // Directed control flow: branch wrap, fall-through, pc 15 wrap
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // pc1 -> 13
        do_instr(5, 1'b1, 1'b0, 1'b0, 1'b1);   // pc13, Z=1 -> 0 (long stall)
        do_instr(1, 1'b0, 1'b0, 1'b0, 1'b1);   // pc0 -> 1
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // pc1 -> 13
        do_instr(2, 1'b0, 1'b1, 1'b1, 1'b1);   // pc13, Z=0 -> 14
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // pc14 -> 15
        do_instr(0, 1'b1, 1'b1, 1'b1, 1'b1);   // pc15, 0000 -> 0
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // 0 -> 1
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // 1 -> 13
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // 13 -> 14
        wait_valid();
        rom[15] = 16'hE001;                    // fetched only after this handover
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // 14 -> 15
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b0);   // pc15, E001 -> 1, then IDLE

        // Randomized program (no jump-to-self)
        for (int i = 0; i < 16; i++) begin
            w = 16'($urandom);
            if ($urandom_range(1, 0) == 1) w[15:13] = 3'b111;
            if (w == 16'hE0FF) w = 16'h0000;
            rom[i] = w;
        end
        for (int k = 0; k < 40; k++) begin
            do_instr(int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(3, 0) != 0);
        end
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Halt on jump-to-self, then reset out of HALT
        for (int i = 0; i < 16; i++) rom[i] = 16'hE0FF;
        do_instr(1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) begin
            ex_ready = 1'($urandom);
            run      = 1'($urandom);
            @(negedge Clock);
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_valid", {31'd0, ir_valid}, 32'd0);
            chk("halt_pc", pc, mpc[3:0]);
        end
        ex_ready = 1'b0; run = 1'b0;
        Reset = 1'b1;
        #1;
        chk("hrst_pc", pc, 4'd0);
        chk("hrst_halted", {31'd0, halted}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        mpc = 0;

        // Asynchronous reset while an instruction waits in WAIT_EX
        for (int i = 0; i < 16; i++) rom[i] = 16'h2000 + 16'(i * 3);
        rom[0] = 16'h2345;
        rom[1] = 16'hF6A5;
        run = 1'b1;
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // 0 -> 1
        wait_valid();
        check_fields();
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("arst_pc", pc, 4'd0);
        chk("arst_ir", ir, 16'h0);
        chk("arst_fields", {opcode, rx, ry, imm}, 16'h0);
        chk("arst_valid", {31'd0, ir_valid}, 32'd0);
        #1 Reset = 1'b0;
        mpc = 0;
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1);   // first fetch reads b0I again
        do_instr(0, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i281_fetch_decode.md
I281_FETCH_DECODE -- requirements
Module: i281_fetch_decode

Interface
REQ-001 SHALL have: Clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have: Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: b0I..b15I  input  16 each  instruction words 0..15 from the instruction ROM, treated as static.
REQ-004 SHALL have: run  input  1  fetch enable; low holds the block in IDLE.
REQ-005 SHALL have: flag_z, flag_n, flag_v  input  1 each  ALU zero, negative and overflow flags.
REQ-006 SHALL have: ex_ready  input  1  execute stage accepts the current decoded instruction.
REQ-007 SHALL have: pc  output  4  address of the instruction being fetched or held.
REQ-008 SHALL have: ir  output  16  latched instruction word.
REQ-009 SHALL have: opcode[3:0], rx[1:0], ry[1:0], imm[7:0]  outputs  decoded fields ir[15:12], ir[11:10], ir[9:8], ir[7:0].
REQ-010 SHALL have: ir_valid  output  1  decoded fields valid toward execute.
REQ-011 SHALL have: halted  output  1  block stopped on a halt instruction.

Function
REQ-012 SHALL implement a state machine with states IDLE, FETCH, DECODE, WAIT_EX and HALT.
REQ-013 SHALL leave IDLE for FETCH on the first rising edge with run=1.
REQ-014 In FETCH, SHALL load ir with word b[pc] (16:1 selection), then go to DECODE.
REQ-015 In DECODE, SHALL register opcode, rx, ry and imm from ir, then go to WAIT_EX with ir_valid=1.
REQ-016 ir_valid SHALL be 1 only in WAIT_EX, so fetch-to-valid latency is 2 cycles.
REQ-017 In WAIT_EX, SHALL hold all outputs stable until ex_ready=1; the transfer happens on the edge where ir_valid and ex_ready are both 1.
REQ-018 On transfer, SHALL sample flag_z, flag_n and flag_v in that same cycle and update pc.
  - Taken branch: pc <= pc + 1 + imm[3:0], modulo 16; the 8-bit two's-complement offset is truncated to 4 bits.
  - Otherwise: pc <= pc + 1, modulo 16 (15 wraps to 0).
REQ-019 Branch decision:
  - opcode 1110 (JUMP): always taken.
  - opcode 1111: condition selected by rx, with 00 = Z, 01 = !Z, 10 = !Z & (N==V), 11 = (N==V).
  - All other opcodes: not taken.
REQ-020 Next state after transfer:
  - opcode 1110 with imm = 8'hFF (jump-to-self): HALT.
  - Otherwise, if run=1: FETCH.
  - Otherwise, if run=0: IDLE.
REQ-021 In HALT, SHALL hold halted=1, ir_valid=0 and pc unchanged; HALT is left only by Reset.
REQ-022 SHALL ignore run=0 while in FETCH, DECODE or WAIT_EX; the current instruction completes before IDLE is entered.
REQ-023 SHALL NOT fetch while in WAIT_EX; at most one instruction is in flight.

Reset
REQ-024 While Reset=1, regardless of Clock, SHALL force state=IDLE, pc=0, ir=0, opcode/rx/ry/imm=0, ir_valid=0 and halted=0.
REQ-025 Reset asserted in any state, including mid-handshake, SHALL discard the in-flight instruction with no pc update.
REQ-026 After deassertion, the first fetch SHALL read b0I.

Structure
REQ-027 A shared package i281_pkg SHALL hold:
  - the opcode constants (JUMP=4'b1110, BRANCH=4'b1111);
  - the branch condition codes;
  - the state enumeration;
  - the field bit-position constants;
  - HALT_OFFSET = 8'hFF.
REQ-028 Branch evaluation SHALL be one combinational sub-module, i281_branch_eval, with inputs opcode, rx, flag_z, flag_n, flag_v and output taken; the mux, IR, PC and FSM stay in the top level.

Verification
REQ-029 Reset, run=1, ex_ready=1, b0I=16'h3004 -> ir=16'h3004 two cycles after the first FETCH edge, opcode=3, rx=0, ry=0, imm=8'h04, ir_valid=1.
REQ-030 pc=13, b13I=16'hF002, flag_z=1 at handshake -> next pc=0 (13+1+2, wrapped); with flag_z=0 -> next pc=14.
REQ-031 pc=15, word=16'h0000 -> next pc=0; pc=15, word=16'hE001 -> next pc=1.
REQ-032 ex_ready held 0 for 5 cycles in WAIT_EX -> ir, pc and fields unchanged, ir_valid=1 throughout, no new fetch.
REQ-033 Word=16'hE0FF -> halted=1 and pc unchanged thereafter; Reset mid-HALT -> pc=0, halted=0, state=IDLE.
REQ-034 Reset pulsed asynchronously during WAIT_EX -> outputs cleared immediately without a Clock edge; the next fetch reads b0I.
